// File: rtl/mux_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_serial_pkg
// Description : Shared types and helpers for the MUX serial frame sequencer.
//               Holds the sequencer state encoding and the counter-width
//               function.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_serial_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        TX      = 3'd2,
        RX      = 3'd3,
        CAPTURE = 3'd4,
        GAP     = 3'd5
    } state_t;

    // Width needed to hold the largest phase length of a frame
    function automatic int cntWidth(input int txWidth, input int rxWidth, input int gapCycles);
        int m;
        m = txWidth;
        if (rxWidth > m) m = rxWidth;
        if (gapCycles > m) m = gapCycles;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_serial_ctrl
// Description : Frame sequencer for the MUX serial link. Accepts one command
//               per handshake, strobes an external TX shift register (load,
//               then shift MSB first), optionally strobes an external RX
//               shift register, captures the received word and returns one
//               response per command. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_serial_ctrl
    import mux_serial_pkg::*;
#(
    parameter int TX_WIDTH   = 5,
    parameter int RX_WIDTH   = 5,
    parameter int GAP_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                cmdValid,
    output logic                cmdReady,
    input  logic                cmdRead,
    input  logic [TX_WIDTH-1:0] cmdData,
    output logic                txLoad,
    output logic                txShift,
    output logic                rxShift,
    input  logic [RX_WIDTH-1:0] rxData,
    output logic [TX_WIDTH-1:0] txWord,
    output logic                serCsN,
    output logic                serClkEn,
    output logic                rspValid,
    input  logic                rspReady,
    output logic [RX_WIDTH-1:0] rspData,
    output logic                busy
);

    localparam int c_CNT_W = cntWidth(TX_WIDTH, RX_WIDTH, GAP_CYCLES);

    // Each phase counter is loaded with (length - 1) and the phase ends at zero
    localparam logic [c_CNT_W-1:0] c_TX_LAST  = c_CNT_W'(TX_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_RX_LAST  = c_CNT_W'(RX_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
    localparam logic               c_HAS_GAP  = (GAP_CYCLES > 0);

    state_t               r_state;
    state_t               w_nextState;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_nextCnt;
    logic                 r_isRead;
    logic                 w_accept;
    logic                 w_rspSet;
    logic                 w_rspFromRx;
    logic                 w_nextRspValid;

    // cmdReady is a registered copy of (IDLE && no pending response)
    assign w_accept = cmdValid && cmdReady;

    // Next-state, phase counter and response bookkeeping
    always_comb begin
        w_nextState    = r_state;
        w_nextCnt      = r_cnt;
        w_rspSet       = 1'b0;
        w_rspFromRx    = 1'b0;
        w_nextRspValid = rspValid;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_nextState = TX;
                w_nextCnt   = c_TX_LAST;
            end
            TX: begin
                if (r_cnt == '0) begin
                    if (r_isRead) begin
                        w_nextState = RX;
                        w_nextCnt   = c_RX_LAST;
                    end else begin
                        w_rspSet = 1'b1;
                        if (c_HAS_GAP) begin
                            w_nextState = GAP;
                            w_nextCnt   = c_GAP_LAST;
                        end else begin
                            w_nextState = IDLE;
                        end
                    end
                end else begin
                    w_nextCnt = r_cnt - c_ONE;
                end
            end
            RX: begin
                if (r_cnt == '0) begin
                    w_nextState = CAPTURE;
                end else begin
                    w_nextCnt = r_cnt - c_ONE;
                end
            end
            CAPTURE: begin
                w_rspSet    = 1'b1;
                w_rspFromRx = 1'b1;
                if (c_HAS_GAP) begin
                    w_nextState = GAP;
                    w_nextCnt   = c_GAP_LAST;
                end else begin
                    w_nextState = IDLE;
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextCnt = r_cnt - c_ONE;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase

        // A new response cannot coincide with a pending one: nothing is
        // accepted while rspValid is high.
        if (w_rspSet) begin
            w_nextRspValid = 1'b1;
        end else if (rspValid && rspReady) begin
            w_nextRspValid = 1'b0;
        end
    end

    // State register, phase counter and latched command
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_isRead <= 1'b0;
            txWord   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_accept) begin
                r_isRead <= cmdRead;
                txWord   <= cmdData;
            end
        end
    end

    // Registered outputs decoded from the upcoming state so they line up
    // exactly with the state they belong to
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cmdReady <= 1'b0;
            txLoad   <= 1'b0;
            txShift  <= 1'b0;
            rxShift  <= 1'b0;
            serClkEn <= 1'b0;
            serCsN   <= 1'b1;
            busy     <= 1'b0;
            rspValid <= 1'b0;
            rspData  <= '0;
        end else begin
            cmdReady <= (w_nextState == IDLE) && !w_nextRspValid;
            txLoad   <= (w_nextState == LOAD);
            // No shift on the last TX cycle so the final bit is held a full cycle
            txShift  <= (w_nextState == TX) && (w_nextCnt != '0);
            rxShift  <= (w_nextState == RX);
            serClkEn <= (w_nextState == TX) || (w_nextState == RX);
            serCsN   <= !((w_nextState == LOAD) || (w_nextState == TX) ||
                          (w_nextState == RX)   || (w_nextState == CAPTURE));
            busy     <= (w_nextState != IDLE);
            rspValid <= w_nextRspValid;
            if (w_rspSet) begin
                rspData <= w_rspFromRx ? rxData : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mux_serial_ctrl.md
Name: mux_serial_ctrl

Overview:
Frame sequencer for the MUX serial link. It takes one command per handshake and drives the parallel-load/shift strobes of a shift_reg_out instance (TX word, MSB first). For read commands it then drives the enable of a shift_reg_in instance (RX word) and captures the received word. It also drives the link chip-select and serial-clock gate, and returns a response per command. It sits between the MUX register interface and the two shift registers, which are instantiated alongside it in the parent.

Parameters:
TX_WIDTH, 5, bits shifted out per frame (matches shift_reg_out WIDTH); legal range 2 to 32
RX_WIDTH, 5, bits shifted in on read frames (matches shift_reg_in WIDTH); legal range 2 to 32
GAP_CYCLES, 2, idle cycles with serCsN high after each frame; 0 allowed (GAP skipped)

Ports:
CLK  in  1  system clock; all logic on posedge
RESETn  in  1  asynchronous, active-low reset
cmdValid  in  1  command offered
cmdReady  out  1  command accepted when cmdValid && cmdReady at posedge
cmdRead  in  1  1 = TX then RX frame; 0 = TX-only (write)
cmdData  in  TX_WIDTH  word to transmit
txLoad  out  1  to shift_reg_out loadData
txShift  out  1  to shift_reg_out clockEnable
rxShift  out  1  to shift_reg_in clockEnable
rxData  in  RX_WIDTH  from shift_reg_in dataOut
txWord  out  TX_WIDTH  latched cmdData, to shift_reg_out dataIn
serCsN  out  1  link chip select, active low
serClkEn  out  1  serial clock gate, high during bit cycles
rspValid  out  1  response available
rspReady  in  1  response consumed when rspValid && rspReady at posedge
rspData  out  RX_WIDTH  received word; 0 for write commands
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs registered. Reset (asynchronous, RESETn low): state IDLE, serCsN=1, all other outputs 0, counters 0. A reset mid-frame aborts the frame with no response.
- States: IDLE, LOAD, TX, RX, CAPTURE, GAP.
- cmdReady = (state==IDLE) && !rspValid. Nothing is accepted while a response is pending.
- IDLE -> LOAD on accept. Latch cmdRead; cmdData goes to txWord.
- LOAD: exactly 1 cycle; txLoad=1, serCsN=0. shift_reg_out loads on this cycle's negedge.
- TX: exactly TX_WIDTH cycles, bit counter 0..TX_WIDTH-1.
  - serCsN=0, serClkEn=1.
  - txShift=1 in TX cycles 0..TX_WIDTH-2 and 0 in the last cycle, so each bit is presented for one full cycle.
  - Exit TX to RX if cmdRead, else to GAP.
- RX: exactly RX_WIDTH cycles; rxShift=1, serClkEn=1, serCsN=0.
- CAPTURE: 1 cycle; rxShift=0, serClkEn=0, serCsN=0.
  - At the posedge ending CAPTURE, rspData <= rxData. This is the value sampled before shift_reg_in clears.
- Response:
  - rspValid is set at the edge leaving TX (write) or CAPTURE (read).
  - For writes, rspData=0.
  - rspValid stays high and rspData stays stable until rspReady is seen; it clears on that edge.
- GAP: GAP_CYCLES cycles with serCsN=1, serClkEn=0, then IDLE. With GAP_CYCLES=0, go directly to IDLE.
- Latency from accept edge to rspValid high: write 1+TX_WIDTH cycles; read 2+TX_WIDTH+RX_WIDTH cycles.
- rspReady held high continuously: the response clears one cycle after it appears. The next command can then be accepted after the gap ends.
- cmdValid while busy: ignored; the command stays pending on the requester side.
- Counters are sized $clog2(max(TX_WIDTH,RX_WIDTH,GAP_CYCLES)+1). No wrap occurs, because every state exits on an exact count.

Decomposition:
- Package mux_serial_pkg holds:
  - the state enum (IDLE, LOAD, TX, RX, CAPTURE, GAP);
  - a localparam function for the counter width.
- No sub-module: the single FSM and down-counter fit in one module. The shift registers are instantiated in the parent, not here.

Test Plan:
- Reset: RESETn=0 at any time -> serCsN=1, cmdReady=0 during reset, all strobes 0; after release, cmdReady=1.
- Write, cmdData=5'b10110, cmdRead=0:
  - txLoad pulses 1 cycle after accept; txShift high for 4 cycles.
  - Serial line (via shift_reg_out) carries 1,0,1,1,0.
  - rspValid at accept+6 with rspData=0.
- Read, cmdData=5'b00011, slave model returns 5'b11001:
  - rxShift high for 5 cycles.
  - rspValid at accept+12 with rspData=5'b11001.
- Back-pressure: hold rspReady=0 for 10 cycles after a write -> rspValid and rspData stable, cmdReady=0 while cmdValid=1; then rspReady=1 -> the next command is accepted after GAP.
- Mid-frame reset: assert RESETn=0 during TX cycle 2 -> serCsN=1 and txShift=0 immediately; no rspValid; a fresh read completes correctly afterwards.
- GAP_CYCLES=0, back-to-back writes with rspReady=1 -> serCsN high for exactly the IDLE cycles between frames and no strobe overlap.
